button_events: RTL and testbench
================================

Name: button_events

Overview:
- Input-side counterpart to the LED drivers: turns a raw, bouncy, asynchronous pushbutton pin into clean single-cycle events.
- Events are press, release and long-press, plus a debounced level and a running press count.
- Sits between a board input pin and the LED/mode-sequencing logic in the 12 MHz `clk` domain.
- Downstream logic advances its state only on `press_pulse` or `long_pulse`. It never samples the raw pin.

Parameters:
- DEBOUNCE_CYCLES, 120000, consecutive synchronized cycles the input must differ from the stable state before the change is accepted (10 ms at 12 MHz); legal range ≥ 2.
- LONG_CYCLES, 12000000, cycles the stable level must remain pressed, counted from the press_pulse cycle, before long_pulse fires (1 s); legal range ≥ 2.
- ACTIVE_LOW, 1, 1 = pin reads 0 when pressed (pull-up button); 0 = pin reads 1 when pressed.
- COUNT_W, 8, width of press_count.

Ports:
- clk  input  1  12 MHz system clock
- rst  input  1  synchronous, active-high reset
- btn_pin  input  1  raw asynchronous button pin
- btn_level  output  1  debounced level, 1 = pressed
- press_pulse  output  1  one-cycle strobe on accepted press
- release_pulse  output  1  one-cycle strobe on accepted release
- long_pulse  output  1  one-cycle strobe when held for LONG_CYCLES
- press_count  output  COUNT_W  number of accepted presses, modulo 2^COUNT_W

Behaviour:
- Clock and reset:
  - Single clock `clk`. Reset `rst` is synchronous and active-high, sampled on posedge clk.
- Input conditioning:
  - Normalize the pin: pressed_raw = btn_pin XOR ACTIVE_LOW.
  - pressed_raw passes through a 2-flop synchronizer (sync1, sync2). Only sync2 is used downstream.
- Reset state, applied on the clock edge where rst=1:
  - sync1 = sync2 = 0 (released), so there is no false press out of reset.
  - State = IDLE; both counters = 0; btn_level = 0; all pulses = 0; press_count = 0.
- State machine:
  - IDLE (stable released, btn_level=0):
    - sync2=1 → PRESS_WAIT, deb_cnt=1.
  - PRESS_WAIT:
    - sync2=0 → IDLE, deb_cnt=0 (bounce rejected).
    - sync2=1 and deb_cnt=DEBOUNCE_CYCLES-1 → HELD. On that same edge: btn_level←1, press_pulse←1, press_count←press_count+1 (wraps), hold_cnt←0.
    - Otherwise deb_cnt++.
  - HELD (btn_level=1):
    - hold_cnt increments each cycle and saturates at LONG_CYCLES.
    - On the edge where hold_cnt goes from LONG_CYCLES-1 to LONG_CYCLES, long_pulse←1.
    - long_pulse fires at most once per press; there is no auto-repeat.
    - sync2=0 → RELEASE_WAIT, deb_cnt=1. hold_cnt keeps running, so a long-press can still fire while in RELEASE_WAIT.
  - RELEASE_WAIT:
    - sync2=1 → HELD, deb_cnt=0.
    - sync2=0 and deb_cnt=DEBOUNCE_CYCLES-1 → IDLE. On that edge: btn_level←0, release_pulse←1, hold_cnt←0.
    - Otherwise deb_cnt++.
- Latency:
  - A clean pin edge is first seen in sync2 two cycles later.
  - btn_level and the matching pulse rise DEBOUNCE_CYCLES cycles after sync2 first differs.
  - Total: DEBOUNCE_CYCLES+2 cycles from the pin edge.
- Pulse rules:
  - All outputs are registered. Pulses are high exactly one cycle, coincident with the first cycle of the new btn_level.
  - press_pulse and release_pulse are never high together.
  - long_pulse may coincide with the release_pulse cycle only if both thresholds land on the same edge. In that case both assert.
- Widths:
  - Counters are sized with $clog2(DEBOUNCE_CYCLES+1) and $clog2(LONG_CYCLES+1). No overflow is permitted.
- Reset mid-operation:
  - rst in any state returns everything to reset values on that edge. No pulse is emitted on that edge.
  - If the pin is held during and after reset, a normal debounced press is reported DEBOUNCE_CYCLES+2 cycles after rst deasserts.

Test Plan:
1. Clean press: DEBOUNCE_CYCLES=4, LONG_CYCLES=20, ACTIVE_LOW=1.
   - Stimulus: drive btn_pin 1→0 at cycle 10, hold.
   - Required: press_pulse high only at cycle 16, btn_level=1 from cycle 16, press_count=1.
   - Required: long_pulse high only at cycle 36.
2. Bounce rejection:
   - Stimulus: btn_pin toggles 0/1 every 2 cycles for 30 cycles, then returns to 1.
   - Required: press_pulse never asserts, btn_level stays 0, press_count stays 0.
3. Short press then release, same parameters:
   - Stimulus: press at cycle 10, release at cycle 25.
   - Required: press_pulse at 16, release_pulse at 31, btn_level low again from 31, no long_pulse.
4. Release glitch while held:
   - Stimulus: in HELD, btn_pin goes high for 2 cycles then low again.
   - Required: no release_pulse, btn_level stays 1.
   - Required: long_pulse still fires exactly 20 cycles after press_pulse, once only.
5. Wrap and reset mid-press: COUNT_W=2.
   - Stimulus: 5 clean presses.
   - Required: press_count sequence 1,2,3,0,1.
   - Stimulus: assert rst for 1 cycle in PRESS_WAIT.
   - Required: all outputs 0 next cycle, no pulse.
6. Polarity: ACTIVE_LOW=0.
   - Stimulus: btn_pin 0→1.
   - Required: press_pulse after DEBOUNCE_CYCLES+2 cycles.
   - Required: a constant btn_pin=1 through reset yields exactly one press after reset.

Source files
------------

// File: rtl/button_events.sv
// Pushbutton conditioner: synchronizes and debounces a raw pin, then emits
// registered press / release / long-press strobes, a clean level and a press count.
module button_events #(
    parameter int DEBOUNCE_CYCLES = 120000,
    parameter int LONG_CYCLES     = 12000000,
    parameter bit ACTIVE_LOW      = 1'b1,
    parameter int COUNT_W         = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn_pin,
    output logic               btn_level,
    output logic               press_pulse,
    output logic               release_pulse,
    output logic               long_pulse,
    output logic [COUNT_W-1:0] press_count
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(LONG_CYCLES + 1);
    localparam logic [DW-1:0] DEB_ONE   = DW'(1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);

    typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

    state_t             state, state_nx;
    logic               sync1, sync2;
    logic [DW-1:0]      deb_cnt, deb_nx;
    logic [HW-1:0]      hold_cnt, hold_nx;
    logic               level_nx, press_nx, release_nx, long_nx;
    logic [COUNT_W-1:0] count_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1         <= 1'b0;
            sync2         <= 1'b0;
            state         <= IDLE;
            deb_cnt       <= '0;
            hold_cnt      <= '0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            press_count   <= '0;
        end else begin
            sync1         <= btn_pin ^ ACTIVE_LOW;
            sync2         <= sync1;
            state         <= state_nx;
            deb_cnt       <= deb_nx;
            hold_cnt      <= hold_nx;
            btn_level     <= level_nx;
            press_pulse   <= press_nx;
            release_pulse <= release_nx;
            long_pulse    <= long_nx;
            press_count   <= count_nx;
        end
    end

    always_comb begin
        state_nx = state;
        deb_nx   = deb_cnt;
        case (state)
            IDLE: begin
                if (sync2) begin
                    state_nx = PRESS_WAIT;
                    deb_nx   = DEB_ONE;
                end
            end
            PRESS_WAIT: begin
                if (!sync2) begin
                    state_nx = IDLE;
                    deb_nx   = '0;
                end else if (deb_cnt == DEB_LAST) begin
                    state_nx = HELD;
                    deb_nx   = '0;
                end else begin
                    deb_nx = deb_cnt + 1'b1;
                end
            end
            HELD: begin
                if (!sync2) begin
                    state_nx = RELEASE_WAIT;
                    deb_nx   = DEB_ONE;
                end
            end
            RELEASE_WAIT: begin
                if (sync2) begin
                    state_nx = HELD;
                    deb_nx   = '0;
                end else if (deb_cnt == DEB_LAST) begin
                    state_nx = IDLE;
                    deb_nx   = '0;
                end else begin
                    deb_nx = deb_cnt + 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
                deb_nx   = '0;
            end
        endcase
    end

    always_comb begin
        level_nx   = btn_level;
        press_nx   = 1'b0;
        release_nx = 1'b0;
        long_nx    = 1'b0;
        count_nx   = press_count;
        hold_nx    = hold_cnt;
        // Hold timer keeps running through a release bounce; saturation makes long fire once.
        if (state == HELD || state == RELEASE_WAIT) begin
            if (hold_cnt != HOLD_MAX)
                hold_nx = hold_cnt + 1'b1;
            long_nx = (hold_cnt == HOLD_LAST);
        end
        if (state == PRESS_WAIT && state_nx == HELD) begin
            level_nx = 1'b1;
            press_nx = 1'b1;
            count_nx = press_count + 1'b1;
            hold_nx  = '0;
        end
        if (state == RELEASE_WAIT && state_nx == IDLE) begin
            level_nx   = 1'b0;
            release_nx = 1'b1;
            hold_nx    = '0;
        end
    end
endmodule

// File: tb/tb_button_events.sv
// Directed bench for button_events: one active-low instance with a 2-bit count
// and one active-high instance, both with DEBOUNCE_CYCLES=4, LONG_CYCLES=20.
module tb_button_events;
    logic       clk = 1'b0;
    logic       rst_a, pin_a, rst_p, pin_p;
    logic       lvl_a, prs_a, rel_a, lng_a;
    logic [1:0] cnt_a;
    logic       lvl_p, prs_p, rel_p, lng_p;
    logic [7:0] cnt_p;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    button_events #(.DEBOUNCE_CYCLES(4), .LONG_CYCLES(20), .ACTIVE_LOW(1'b1), .COUNT_W(2)) u_a (
        .clk(clk), .rst(rst_a), .btn_pin(pin_a), .btn_level(lvl_a), .press_pulse(prs_a),
        .release_pulse(rel_a), .long_pulse(lng_a), .press_count(cnt_a));

    button_events #(.DEBOUNCE_CYCLES(4), .LONG_CYCLES(20), .ACTIVE_LOW(1'b0), .COUNT_W(8)) u_p (
        .clk(clk), .rst(rst_p), .btn_pin(pin_p), .btn_level(lvl_p), .press_pulse(prs_p),
        .release_pulse(rel_p), .long_pulse(lng_p), .press_count(cnt_p));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_a();
        pin_a = 1'b1;
        rst_a = 1'b1;
        step();
        rst_a = 1'b0;
    endtask

    task automatic test_reset();
        rst_a = 1'b1; pin_a = 1'b1;
        rst_p = 1'b1; pin_p = 1'b0;
        step(); step();
        checks++;
        if ({lvl_a, prs_a, rel_a, lng_a, cnt_a} !== 6'b0) begin
            errors++;
            $display("FAIL reset_a got %b exp 000000", {lvl_a, prs_a, rel_a, lng_a, cnt_a});
        end
        checks++;
        if ({lvl_p, prs_p, rel_p, lng_p, cnt_p} !== 12'b0) begin
            errors++;
            $display("FAIL reset_p got %b exp 0", {lvl_p, prs_p, rel_p, lng_p, cnt_p});
        end
        rst_a = 1'b0;
        rst_p = 1'b0;
    endtask

    // {level, press, release, long} checked every cycle against hand timelines.
    task automatic test_clean_press();
        logic [3:0] exp_v;
        reset_a();
        for (int t = 1; t <= 40; t++) begin
            step();
            exp_v = {t >= 16, t == 16, 1'b0, t == 36};
            checks++;
            if ({lvl_a, prs_a, rel_a, lng_a} !== exp_v) begin
                errors++;
                $display("FAIL clean_press t=%0d got %b exp %b", t, {lvl_a, prs_a, rel_a, lng_a}, exp_v);
            end
            if (t == 10) pin_a = 1'b0;
        end
        checks++;
        if (cnt_a !== 2'd1) begin
            errors++;
            $display("FAIL clean_press_count got %0d exp 1", cnt_a);
        end
    endtask

    task automatic test_bounce();
        reset_a();
        for (int t = 1; t <= 40; t++) begin
            step();
            checks++;
            if ({lvl_a, prs_a, rel_a, lng_a} !== 4'b0) begin
                errors++;
                $display("FAIL bounce t=%0d got %b exp 0000", t, {lvl_a, prs_a, rel_a, lng_a});
            end
            pin_a = (t < 30) ? (((t / 2) % 2) == 0) : 1'b1;
        end
        checks++;
        if (cnt_a !== 2'd0) begin
            errors++;
            $display("FAIL bounce_count got %0d exp 0", cnt_a);
        end
    endtask

    task automatic test_short_press();
        logic [3:0] exp_v;
        reset_a();
        for (int t = 1; t <= 45; t++) begin
            step();
            exp_v = {(t >= 16) && (t < 31), t == 16, t == 31, 1'b0};
            checks++;
            if ({lvl_a, prs_a, rel_a, lng_a} !== exp_v) begin
                errors++;
                $display("FAIL short_press t=%0d got %b exp %b", t, {lvl_a, prs_a, rel_a, lng_a}, exp_v);
            end
            if (t == 10) pin_a = 1'b0;
            if (t == 25) pin_a = 1'b1;
        end
    endtask

    task automatic test_release_glitch();
        logic [3:0] exp_v;
        reset_a();
        for (int t = 1; t <= 60; t++) begin
            step();
            exp_v = {t >= 16, t == 16, 1'b0, t == 36};
            checks++;
            if ({lvl_a, prs_a, rel_a, lng_a} !== exp_v) begin
                errors++;
                $display("FAIL release_glitch t=%0d got %b exp %b", t, {lvl_a, prs_a, rel_a, lng_a}, exp_v);
            end
            if (t == 10) pin_a = 1'b0;
            if (t == 20) pin_a = 1'b1;
            if (t == 22) pin_a = 1'b0;
        end
    endtask

    task automatic test_wrap_and_reset();
        logic [1:0] exp_c;
        logic [3:0] exp_v;
        reset_a();
        for (int i = 0; i < 5; i++) begin
            pin_a = 1'b0;
            for (int t = 1; t <= 12; t++) begin
                step();
                checks++;
                if ({prs_a, rel_a} !== {t == 6, t == 12}) begin
                    errors++;
                    $display("FAIL wrap_pulse i=%0d t=%0d got %b exp %b", i, t, {prs_a, rel_a}, {t == 6, t == 12});
                end
                if (t == 6) begin
                    exp_c = 2'(i + 1);
                    checks++;
                    if (cnt_a !== exp_c) begin
                        errors++;
                        $display("FAIL wrap_count i=%0d got %0d exp %0d", i, cnt_a, exp_c);
                    end
                    pin_a = 1'b1;
                end
            end
        end
        pin_a = 1'b0;
        repeat (4) step();
        rst_a = 1'b1;
        step();
        checks++;
        if ({lvl_a, prs_a, rel_a, lng_a, cnt_a} !== 6'b0) begin
            errors++;
            $display("FAIL mid_reset got %b exp 000000", {lvl_a, prs_a, rel_a, lng_a, cnt_a});
        end
        rst_a = 1'b0;
        for (int t = 1; t <= 10; t++) begin
            step();
            exp_v = {t >= 6, t == 6, 1'b0, 1'b0};
            checks++;
            if ({lvl_a, prs_a, rel_a, lng_a} !== exp_v) begin
                errors++;
                $display("FAIL after_reset t=%0d got %b exp %b", t, {lvl_a, prs_a, rel_a, lng_a}, exp_v);
            end
        end
        checks++;
        if (cnt_a !== 2'd1) begin
            errors++;
            $display("FAIL after_reset_count got %0d exp 1", cnt_a);
        end
    endtask

    task automatic test_polarity();
        logic [3:0] exp_v;
        pin_p = 1'b0;
        rst_p = 1'b1;
        step();
        rst_p = 1'b0;
        for (int t = 1; t <= 12; t++) begin
            step();
            exp_v = {t >= 8, t == 8, 1'b0, 1'b0};
            checks++;
            if ({lvl_p, prs_p, rel_p, lng_p} !== exp_v) begin
                errors++;
                $display("FAIL polarity t=%0d got %b exp %b", t, {lvl_p, prs_p, rel_p, lng_p}, exp_v);
            end
            if (t == 2) pin_p = 1'b1;
        end
        rst_p = 1'b1;
        step(); step();
        checks++;
        if ({lvl_p, prs_p, rel_p, lng_p, cnt_p} !== 12'b0) begin
            errors++;
            $display("FAIL held_reset got %b exp 0", {lvl_p, prs_p, rel_p, lng_p, cnt_p});
        end
        rst_p = 1'b0;
        for (int t = 1; t <= 30; t++) begin
            step();
            exp_v = {t >= 6, t == 6, 1'b0, t == 26};
            checks++;
            if ({lvl_p, prs_p, rel_p, lng_p} !== exp_v) begin
                errors++;
                $display("FAIL held_through_reset t=%0d got %b exp %b", t, {lvl_p, prs_p, rel_p, lng_p}, exp_v);
            end
        end
        checks++;
        if (cnt_p !== 8'd1) begin
            errors++;
            $display("FAIL held_through_reset_count got %0d exp 1", cnt_p);
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_short_press();
        test_release_glitch();
        test_wrap_and_reset();
        test_polarity();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
